pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces the fixed, always-enabled stage latches between core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field under a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with a registered in_ready.
- Adds synchronous flush with bubble insertion, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- CTRL_W, 16: width of the control field (regwrite, memwrite, ALUop, mul_div_op, ...).
- DATA_W, 160: width of the data field (rdata1, rdata2, imm, PC, inst).
- CTRL_BUBBLE, 16'h000F: control value presented when the stage holds no valid entry. Default sets mul_div_op = 4'b1111 (NOP) and every write enable to 0.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous kill of all held entries (branch mispredict / trap).
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream data field.
- out_valid, output, 1: downstream entry valid.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: control field; equals CTRL_BUBBLE whenever out_valid=0.
- out_data, output, DATA_W: data field; value is don't-care when out_valid=0 (holds last value).
- occupancy, output, 2: number of held entries (0..2).
- stall_cnt, output, CNT_W: saturating count of stalled cycles.

Behaviour:
- Priority is reset > flush > normal operation. All state updates on posedge clk.
- Reset values:
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid entry cleared, occupancy=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1. Throughput is 1 entry/cycle while out_ready=1.
- State machine for SKID=1 (occupancy encodes the state):
  - EMPTY:
    - in_fire -> ONE; the entry loads into the main register.
  - ONE:
    - in_fire & out_fire -> ONE; main register reloads with the new entry.
    - in_fire & !out_fire -> FULL; the entry goes to the skid register.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL:
    - in_ready=0.
    - out_fire -> ONE; the skid entry moves to the main register in the same cycle.
- in_ready for SKID=1 is registered and equals (state != FULL). No combinational path from out_ready.
- SKID=0:
  - Single entry; states EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - occupancy never exceeds 1.
- Flush:
  - Next cycle: out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, in_ready=1.
  - An upstream entry presented in the flush cycle is dropped. in_ready is not forced low during flush; the handshake is considered accepted and the entry discarded.
  - An out_fire in the flush cycle still counts as a completed transfer for the downstream stage.
- Ordering: entries are never reordered or duplicated. Main-register data is stable while out_valid & !out_ready.
- stall_cnt:
  - Increments by 1 in each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Reset mid-transfer: held entries are discarded; no out_fire is reported in the reset cycle.

Decomposition:
- Shared package pipe_pkg:
  - stage_state_e enum {EMPTY, ONE, FULL}.
  - Bubble constants: MULDIV_NOP=4'b1111, CTRL_BUBBLE_ID_EX.
  - Control-field struct typedefs per stage, with packed widths matching CTRL_W.
- One sub-module: sat_counter (parameter W; inputs inc, clr) for stall_cnt.

Test Plan:
- Streaming: reset, then in_valid=1 with in_data 1..8 on consecutive cycles and out_ready=1 -> out_data 1..8 on cycles 2..9, occupancy stays 1, stall_cnt=0.
- Backpressure (SKID=1): out_ready=0 after entry 1 -> entry 2 goes to skid, occupancy=2, in_ready=0 next cycle, stall_cnt counts 1,2,3. Then out_ready=1 -> out_data 1, 2, 3 in order with no loss.
- Flush while FULL: flush=1 with in_valid=1 and data 0xAA -> next cycle out_valid=0, out_ctrl=16'h000F, occupancy=0, in_ready=1; 0xAA never appears on out_data.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> simultaneous replace, occupancy stays 1.
- Saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds. Then flush -> stall_cnt stays 15; reset -> 0.
- Reset mid-operation: reset asserted while FULL -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the core's inter-stage pipeline registers.
// Control-field layouts are 16 bits wide so they fit the default CTRL_W of pipe_stage_reg.
package pipe_pkg;

    localparam int unsigned CORE_CTRL_W = 16;

    // Occupancy of a stage register; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam logic [3:0] MULDIV_NOP = 4'b1111;

    typedef struct packed {
        logic        predicted_taken;
        logic        inst_valid;
        logic [13:0] rsvd;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [4:0] aluop;
        logic [3:0] mul_div_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic [2:0] mem_size;
        logic [8:0] rsvd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [13:0] rsvd;
    } mem_wb_ctrl_t;

    // All write enables low, multiplier/divider idle.
    localparam logic [CORE_CTRL_W-1:0] CTRL_BUBBLE_ID_EX = {12'h000, MULDIV_NOP};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = 16,
    parameter int unsigned       DATA_W      = 160,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_ID_EX),
    parameter int unsigned       SKID        = 1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Held entries and any entry accepted this cycle are discarded.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready breaks the out_ready -> in_ready path between stages.
            logic in_ready_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != FULL);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a default skid instance and a single-entry, 4-bit-counter instance.
module tb_pipe_stage_reg;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    // Instance A: SKID=1, default widths.
    logic         a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0]  a_in_ctrl, a_out_ctrl, a_stall;
    logic [159:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;

    // Instance B: SKID=0, 8-bit data, 4-bit stall counter.
    logic         b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0]  b_in_ctrl, b_out_ctrl;
    logic [7:0]   b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_stall;

    pipe_stage_reg u_a (
        .clk       (clk),
        .reset     (a_reset),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_ctrl   (a_in_ctrl),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ctrl  (a_out_ctrl),
        .out_data  (a_out_data),
        .occupancy (a_occ),
        .stall_cnt (a_stall)
    );

    pipe_stage_reg #(
        .DATA_W (8),
        .SKID   (0),
        .CNT_W  (4)
    ) u_b (
        .clk       (clk),
        .reset     (b_reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_ctrl   (b_in_ctrl),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_data  (b_out_data),
        .occupancy (b_occ),
        .stall_cnt (b_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: from one falling edge, across a rising edge, to the next falling edge.
    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_ctrl = '0; a_in_data = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_ctrl = '0; b_in_data = '0;
        next();
        next();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 160'(a_out_valid), 160'(0));
        chk("rst_out_ctrl",  160'(a_out_ctrl),  160'(16'h000F));
        chk("rst_out_data",  a_out_data,        160'(0));
        chk("rst_occ",       160'(a_occ),       160'(0));
        chk("rst_stall",     160'(a_stall),     160'(0));
        chk("rst_in_ready",  160'(a_in_ready),  160'(1));
        chk("rst_b_in_ready", 160'(b_in_ready), 160'(1));

        // Streaming 1..8 with out_ready=1
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_in_data = 160'(k);
            a_in_ctrl = 16'h0100 + 16'(k);
            #1;
            chk("str_out_valid", 160'(a_out_valid), 160'(k > 1));
            chk("str_occ",       160'(a_occ),       160'(k > 1));
            chk("str_in_ready",  160'(a_in_ready),  160'(1));
            if (k > 1) begin
                chk("str_out_data", a_out_data,       160'(k - 1));
                chk("str_out_ctrl", 160'(a_out_ctrl), 160'(16'h0100 + 16'(k - 1)));
            end
            next();
        end
        a_in_valid = 1'b0;
        chk("str_last_data", a_out_data,  160'(8));
        chk("str_last_occ",  160'(a_occ), 160'(1));
        chk("str_stall",     160'(a_stall), 160'(0));
        next();
        chk("str_drain_valid", 160'(a_out_valid), 160'(0));
        chk("str_drain_ctrl",  160'(a_out_ctrl),  160'(16'h000F));

        // Backpressure into the skid register
        a_in_valid = 1'b1; a_in_data = 160'(1); a_in_ctrl = 16'h0201; a_out_ready = 1'b1;
        next();
        a_in_data = 160'(2); a_in_ctrl = 16'h0202; a_out_ready = 1'b0;
        chk("bp_in_ready_one", 160'(a_in_ready), 160'(1));
        chk("bp_data1",        a_out_data,       160'(1));
        next();
        a_in_data = 160'(3); a_in_ctrl = 16'h0203;
        chk("bp_in_ready_full", 160'(a_in_ready), 160'(0));
        chk("bp_occ_full",      160'(a_occ),      160'(2));
        chk("bp_stall1",        160'(a_stall),    160'(1));
        chk("bp_data1_hold",    a_out_data,       160'(1));
        next();
        chk("bp_stall2", 160'(a_stall), 160'(2));
        next();
        chk("bp_stall3",       160'(a_stall), 160'(3));
        chk("bp_occ_full2",    160'(a_occ),   160'(2));
        chk("bp_data1_hold2",  a_out_data,    160'(1));
        a_out_ready = 1'b1;
        next();
        chk("bp_data2",     a_out_data,       160'(2));
        chk("bp_ctrl2",     160'(a_out_ctrl), 160'(16'h0202));
        chk("bp_occ_one",   160'(a_occ),      160'(1));
        chk("bp_in_ready",  160'(a_in_ready), 160'(1));
        chk("bp_stall_hold", 160'(a_stall),   160'(3));
        next();
        chk("bp_data3", a_out_data,  160'(3));
        chk("bp_occ3",  160'(a_occ), 160'(1));
        a_in_valid = 1'b0;
        next();
        chk("bp_empty", 160'(a_occ), 160'(0));

        // Flush while FULL, with an upstream entry offered in the flush cycle
        a_in_valid = 1'b1; a_in_data = 160'(8'h11); a_in_ctrl = 16'h0311; a_out_ready = 1'b0;
        next();
        a_in_data = 160'(8'h22); a_in_ctrl = 16'h0322;
        next();
        chk("fl_occ_full", 160'(a_occ),   160'(2));
        chk("fl_stall",    160'(a_stall), 160'(4));
        a_flush = 1'b1; a_in_data = 160'(8'hAA); a_in_ctrl = 16'h03AA;
        next();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_out_valid", 160'(a_out_valid), 160'(0));
        chk("fl_out_ctrl",  160'(a_out_ctrl),  160'(16'h000F));
        chk("fl_occ",       160'(a_occ),       160'(0));
        chk("fl_in_ready",  160'(a_in_ready),  160'(1));
        chk("fl_stall_kept", 160'(a_stall),    160'(5));
        next();
        chk("fl_still_empty", 160'(a_out_valid), 160'(0));
        chk("fl_no_aa",       a_out_data,        160'(8'h11));

        // Reset while FULL
        a_in_valid = 1'b1; a_in_data = 160'(8'h33); a_in_ctrl = 16'h0433;
        next();
        a_in_data = 160'(8'h44); a_in_ctrl = 16'h0444;
        next();
        chk("rm_occ_full", 160'(a_occ),   160'(2));
        chk("rm_stall",    160'(a_stall), 160'(6));
        a_reset = 1'b1; a_in_valid = 1'b0;
        next();
        a_reset = 1'b0;
        chk("rm_out_valid", 160'(a_out_valid), 160'(0));
        chk("rm_out_ctrl",  160'(a_out_ctrl),  160'(16'h000F));
        chk("rm_out_data",  a_out_data,        160'(0));
        chk("rm_occ",       160'(a_occ),       160'(0));
        chk("rm_stall0",    160'(a_stall),     160'(0));
        chk("rm_in_ready",  160'(a_in_ready),  160'(1));

        // SKID=0: combinational ready and simultaneous replace
        b_in_valid = 1'b1; b_in_data = 8'h01; b_in_ctrl = 16'h0501; b_out_ready = 1'b0;
        #1;
        chk("ns_in_ready_empty", 160'(b_in_ready), 160'(1));
        next();
        b_in_data = 8'h02; b_in_ctrl = 16'h0502;
        #1;
        chk("ns_in_ready_stall", 160'(b_in_ready), 160'(0));
        chk("ns_occ1",           160'(b_occ),      160'(1));
        chk("ns_data1",          160'(b_out_data), 160'(8'h01));
        next();
        b_out_ready = 1'b1;
        #1;
        chk("ns_in_ready_comb", 160'(b_in_ready), 160'(1));
        chk("ns_stall1",        160'(b_stall),    160'(1));
        next();
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        chk("ns_data2", 160'(b_out_data), 160'(8'h02));
        chk("ns_ctrl2", 160'(b_out_ctrl), 160'(16'h0502));
        chk("ns_occ_replace", 160'(b_occ), 160'(1));

        // Saturation of the 4-bit counter, survives flush, cleared by reset
        repeat (20) next();
        chk("sat_stall15", 160'(b_stall),     160'(15));
        chk("sat_occ",     160'(b_occ),       160'(1));
        chk("sat_valid",   160'(b_out_valid), 160'(1));
        b_flush = 1'b1;
        next();
        b_flush = 1'b0;
        chk("sat_flush_keep",  160'(b_stall),     160'(15));
        chk("sat_flush_valid", 160'(b_out_valid), 160'(0));
        chk("sat_flush_ctrl",  160'(b_out_ctrl),  160'(16'h000F));
        chk("sat_flush_occ",   160'(b_occ),       160'(0));
        b_reset = 1'b1;
        next();
        b_reset = 1'b0;
        chk("sat_reset_clear", 160'(b_stall), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
